spi_xfer_master: RTL and testbench

SPI_XFER_MASTER -- requirements
Module: spi_xfer_master

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_xfer_master_if.sv | 42 ++++
 rtl/spi_clk_gen.sv | 29 ++
 rtl/spi_xfer_master.sv | 114 +++++++++++
 tb/tb_spi_xfer_master.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transfer master: FSM state encoding,
// default frame/select/divider constants and small sizing helpers.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE
  } spi_state_t;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_N_CS   = 2;
  localparam int DEF_DIV    = 4;

  // Chip-select index width, never narrower than one bit.
  function automatic int cs_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic sel_ok(input int sel, input int n);
    return sel < n;
  endfunction

endpackage

// File: rtl/spi_xfer_master_if.sv
// Request/serial bundle of the SPI transfer master. The loopback select only
// exists when SPI_LOOPBACK_EN is defined.
interface spi_xfer_master_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CS   = DEF_N_CS,
  parameter int CS_W   = cs_w(N_CS)
);
  logic              start;
  logic [CS_W-1:0]   cs_sel;
  logic [DATA_W-1:0] tx_data;
  logic              abort;
  logic              miso;
  logic              sclk;
  logic              mosi;
  logic [N_CS-1:0]   cs_n;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              err;
`ifdef SPI_LOOPBACK_EN
  logic              loopback;
`endif

  modport master (
`ifdef SPI_LOOPBACK_EN
    input  loopback,
`endif
    input  start, cs_sel, tx_data, abort, miso,
    output sclk, mosi, cs_n, rx_data, busy, done, err
  );

  modport slave (
`ifdef SPI_LOOPBACK_EN
    output loopback,
`endif
    output start, cs_sel, tx_data, abort, miso,
    input  sclk, mosi, cs_n, rx_data, busy, done, err
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK half-period tick generator: counts 0..DIV-1 while enabled and pulses
// tick on the last count; held at zero whenever the transfer is not active.
module spi_clk_gen #(
  parameter int DIV = 4
) (
  input  logic clk_master,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = (DIV <= 1) ? 1 : $clog2(DIV);

  logic [CNT_W-1:0] cnt;
  logic             last;

  assign last = (cnt == CNT_W'(DIV - 1));
  assign tick = en && last;

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_xfer_master.sv
// Mode-0 SPI frame master: one DATA_W-bit full-duplex frame per accepted start,
// MSB first. Define SPI_LOOPBACK_EN to add an internal mosi->rx loopback select.
module spi_xfer_master
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_CS   = DEF_N_CS,
  parameter int DIV    = DEF_DIV
) (
  input  logic               clk_master,
  input  logic               rst,
  spi_xfer_master_if.master  bus
);
  localparam int CS_W  = cs_w(N_CS);
  localparam int CNT_W = $clog2(DATA_W + 1);

  spi_state_t        state, state_nxt;
  logic              tick;
  logic              active;
  logic              phase;      // 0: SCLK high half, 1: SCLK low half
  logic [CNT_W-1:0]  bit_cnt;    // completed SCLK periods
  logic [CS_W-1:0]   cs_lat;
  logic              err_r;
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_data_r;
  logic [N_CS-1:0]   cs_n_w;
  logic              start_ok, accept, rising, falling, last_bit, sample_bit;

  assign active   = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
  assign start_ok = sel_ok(int'(bus.cs_sel), N_CS);
  assign accept   = (state == ST_IDLE) && bus.start && start_ok;
  assign last_bit = (bit_cnt == CNT_W'(DATA_W));

  // SCLK rises on SETUP->SHIFT and at the end of every low half except the last.
  assign rising  = ((state == ST_SETUP) && tick) ||
                   ((state == ST_SHIFT) && tick && phase && !last_bit);
  assign falling = (state == ST_SHIFT) && tick && !phase;

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = bus.loopback ? tx_sh[DATA_W-1] : bus.miso;
`else
  assign sample_bit = bus.miso;
`endif

  spi_clk_gen #(.DIV(DIV)) u_clk_gen (
    .clk_master (clk_master),
    .rst        (rst),
    .en         (active),
    .tick       (tick)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SETUP;
      ST_SETUP: if (bus.abort) state_nxt = ST_IDLE;
                else if (tick) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bus.abort) state_nxt = ST_IDLE;
                else if (tick && phase && last_bit) state_nxt = ST_HOLD;
      ST_HOLD:  if (bus.abort) state_nxt = ST_IDLE;
                else if (tick) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_master or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      cs_lat    <= '0;
      err_r     <= 1'b0;
      rx_data_r <= '0;
    end else begin
      state <= state_nxt;
      err_r <= (state == ST_IDLE) && bus.start && !start_ok;
      if (accept) cs_lat <= bus.cs_sel;
      if (state == ST_SETUP) begin
        phase   <= 1'b0;
        bit_cnt <= '0;
      end else if (falling) begin
        phase   <= 1'b1;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else if (rising) begin
        phase   <= 1'b0;
      end
      if (state_nxt == ST_DONE) rx_data_r <= rx_sh;
    end
  end

  // Shift registers carry no reset: mosi is gated by active and rx_data is
  // only loaded from a fully shifted frame.
  always_ff @(posedge clk_master) begin
    if (accept) tx_sh <= bus.tx_data;
    else if (falling) tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
    if (rising) rx_sh <= {rx_sh[DATA_W-2:0], sample_bit};
  end

  always_comb begin
    cs_n_w = '1;
    for (int i = 0; i < N_CS; i++) begin
      if (active && (int'(cs_lat) == i)) cs_n_w[i] = 1'b0;
    end
  end

  assign bus.sclk    = (state == ST_SHIFT) && !phase;
  assign bus.mosi    = active && tx_sh[DATA_W-1];
  assign bus.cs_n    = cs_n_w;
  assign bus.rx_data = rx_data_r;
  assign bus.busy    = active;
  assign bus.done    = (state == ST_DONE);
  assign bus.err     = err_r;

endmodule

// File: tb/tb_spi_xfer_master.sv
// Randomized bench for spi_xfer_master: a slave model shifts a word out on miso
// while the reference expects tx on mosi, the slave word in rx_data and the
// closed-form start-to-done latency.
module tb_spi_xfer_master;
  import spi_pkg::*;

  logic clk_master = 1'b0;
  logic rst;
  always #5 clk_master = ~clk_master;

  spi_xfer_master_if #(.DATA_W(8),   .N_CS(2)) a_if ();
  spi_xfer_master_if #(.DATA_W(128), .N_CS(2)) b_if ();
  spi_xfer_master_if #(.DATA_W(8),   .N_CS(3)) c_if ();

  spi_xfer_master #(.DATA_W(8), .N_CS(2), .DIV(2)) dut_a (
    .clk_master (clk_master), .rst (rst), .bus (a_if.master));
  spi_xfer_master dut_b (
    .clk_master (clk_master), .rst (rst), .bus (b_if.master));
  spi_xfer_master #(.DATA_W(8), .N_CS(3), .DIV(1)) dut_c (
    .clk_master (clk_master), .rst (rst), .bus (c_if.master));

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] ref_rx_a;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 normal, 1 abort after 3 SCLK periods, 2 reset mid-SHIFT, 3 abort with start
  task automatic xfer_a(input logic [7:0] tx, input logic [7:0] sl, input logic sel,
                        input int mode, input logic busy_start);
    logic [7:0] cap, sh, exp_rx;
    logic [1:0] exp_cs;
    int         rises, falls, cyc;
    logic       prev_sclk, saw_done, cs_ok;
    exp_cs = sel ? 2'b01 : 2'b10;
    exp_rx = sl;
`ifdef SPI_LOOPBACK_EN
    if (a_if.loopback) exp_rx = tx;
`endif
    sh = sl;
    a_if.miso    = sh[7];
    a_if.tx_data = tx;
    a_if.cs_sel  = sel;
    a_if.start   = 1'b1;
    a_if.abort   = (mode == 3);
    cap = '0; rises = 0; falls = 0; cyc = 0;
    prev_sclk = 1'b0; saw_done = 1'b0; cs_ok = 1'b1;
    while (!saw_done && cyc < 100) begin
      @(negedge clk_master);
      cyc++;
      if (cyc == 1) begin
        a_if.start = 1'b0;
        a_if.abort = 1'b0;
        chk("a_busy_rise", 128'(a_if.busy), 128'(1));
        chk("a_cs_n_first", 128'(a_if.cs_n), 128'(exp_cs));
      end
      if (busy_start && cyc == 12) begin
        a_if.start   = 1'b1;
        a_if.cs_sel  = ~sel;
        a_if.tx_data = ~tx;
      end
      if (busy_start && cyc == 13) a_if.start = 1'b0;
      if (a_if.sclk && !prev_sclk) begin
        cap = {cap[6:0], a_if.mosi};
        rises++;
      end
      if (!a_if.sclk && prev_sclk) begin
        sh = {sh[6:0], 1'b0};
        a_if.miso = sh[7];
        falls++;
      end
      prev_sclk = a_if.sclk;
      if (a_if.busy && a_if.cs_n !== exp_cs) cs_ok = 1'b0;
      if (a_if.done) saw_done = 1'b1;
      else if (mode == 1 && falls == 3) begin
        a_if.abort = 1'b1;
        @(negedge clk_master);
        a_if.abort = 1'b0;
        chk("abort_cs_n", 128'(a_if.cs_n), 128'(2'b11));
        chk("abort_sclk", 128'(a_if.sclk), 128'(0));
        chk("abort_busy", 128'(a_if.busy), 128'(0));
        for (int k = 0; k < 40; k++) begin
          if (a_if.done) saw_done = 1'b1;
          @(negedge clk_master);
        end
        chk("abort_no_done", 128'(saw_done), 128'(0));
        chk("abort_rx_hold", 128'(a_if.rx_data), 128'(ref_rx_a));
        chk("abort_cs_frame", 128'(cs_ok), 128'(1));
        return;
      end else if (mode == 2 && falls == 2) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_async_cs_n", 128'(a_if.cs_n), 128'(2'b11));
        chk("rst_async_sclk", 128'(a_if.sclk), 128'(0));
        chk("rst_async_mosi", 128'(a_if.mosi), 128'(0));
        chk("rst_async_busy", 128'(a_if.busy), 128'(0));
        chk("rst_async_rx", 128'(a_if.rx_data), 128'(0));
        @(negedge clk_master);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
          if (a_if.done || a_if.busy) saw_done = 1'b1;
          @(negedge clk_master);
        end
        chk("rst_no_done", 128'(saw_done), 128'(0));
        ref_rx_a = '0;
        return;
      end
    end
    chk("a_latency", 128'(cyc), 128'(1 + 2 * (2 * 8 + 2)));
    chk("a_rx_data", 128'(a_if.rx_data), 128'(exp_rx));
    chk("a_mosi_bits", 128'(cap), 128'(tx));
    chk("a_sclk_rises", 128'(rises), 128'(8));
    chk("a_cs_frame", 128'(cs_ok), 128'(1));
    @(negedge clk_master);
    chk("a_done_pulse", 128'({a_if.done, a_if.busy, a_if.cs_n}), 128'(4'b0011));
    ref_rx_a = exp_rx;
  endtask

  task automatic xfer_b(input logic [127:0] tx, input logic [127:0] sl);
    logic [127:0] cap, sh;
    int           rises, cyc;
    logic         prev_sclk, cs_ok;
    sh = sl;
    b_if.miso = sh[127];
    b_if.tx_data = tx;
    b_if.cs_sel = 1'b1;
    b_if.start = 1'b1;
    cap = '0; rises = 0; cyc = 0; prev_sclk = 1'b0; cs_ok = 1'b1;
    while (!b_if.done && cyc < 1200) begin
      @(negedge clk_master);
      cyc++;
      b_if.start = 1'b0;
      if (b_if.sclk && !prev_sclk) begin
        cap = {cap[126:0], b_if.mosi};
        rises++;
      end
      if (!b_if.sclk && prev_sclk) begin
        sh = {sh[126:0], 1'b0};
        b_if.miso = sh[127];
      end
      prev_sclk = b_if.sclk;
      if (b_if.busy && b_if.cs_n !== 2'b01) cs_ok = 1'b0;
    end
    chk("b_latency", 128'(cyc), 128'(1 + 4 * (2 * 128 + 2)));
    chk("b_sclk_rises", 128'(rises), 128'(128));
    chk("b_mosi_bits", cap, tx);
    chk("b_rx_data", b_if.rx_data, sl);
    chk("b_cs_frame", 128'(cs_ok), 128'(1));
  endtask

  task automatic err_c();
    int cyc;
    @(negedge clk_master);
    c_if.cs_sel = 2'd3;
    c_if.start  = 1'b1;
    @(negedge clk_master);
    c_if.start = 1'b0;
    chk("c_err_pulse", 128'(c_if.err), 128'(1));
    chk("c_err_busy", 128'(c_if.busy), 128'(0));
    chk("c_err_cs_n", 128'(c_if.cs_n), 128'(3'b111));
    @(negedge clk_master);
    chk("c_err_one_cycle", 128'({c_if.err, c_if.busy, c_if.cs_n}), 128'(5'b00111));
    c_if.miso   = 1'b1;
    c_if.cs_sel = 2'd2;
    c_if.start  = 1'b1;
    @(negedge clk_master);
    c_if.start = 1'b0;
    chk("c_cs_n_sel2", 128'(c_if.cs_n), 128'(3'b011));
    cyc = 1;
    while (!c_if.done && cyc < 60) begin
      @(negedge clk_master);
      cyc++;
    end
    chk("c_latency", 128'(cyc), 128'(1 + 1 * (2 * 8 + 2)));
    chk("c_rx_data", 128'(c_if.rx_data), 128'(8'hFF));
  endtask

  initial begin
    rst = 1'b1;
    a_if.start = 1'b0; a_if.cs_sel = '0; a_if.tx_data = '0; a_if.abort = 1'b0; a_if.miso = 1'b0;
    b_if.start = 1'b0; b_if.cs_sel = '0; b_if.tx_data = '0; b_if.abort = 1'b0; b_if.miso = 1'b0;
    c_if.start = 1'b0; c_if.cs_sel = '0; c_if.tx_data = '0; c_if.abort = 1'b0; c_if.miso = 1'b0;
`ifdef SPI_LOOPBACK_EN
    a_if.loopback = 1'b0; b_if.loopback = 1'b0; c_if.loopback = 1'b0;
`endif
    ref_rx_a = '0;
    repeat (3) @(negedge clk_master);
    chk("reset_outputs", 128'({a_if.cs_n, a_if.sclk, a_if.mosi, a_if.busy, a_if.done, a_if.err}),
        128'(7'b1100000));
    chk("reset_rx", 128'(a_if.rx_data), 128'(0));
    rst = 1'b0;
    @(negedge clk_master);

    xfer_a(8'hA5, 8'h3C, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++)
      xfer_a(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0, (i == 1) || (i == 3));
    xfer_a(8'($urandom), 8'($urandom), 1'b1, 1, 1'b0);
    xfer_a(8'($urandom), 8'($urandom), 1'b0, 3, 1'b0);
    xfer_a(8'($urandom), 8'($urandom), 1'b1, 2, 1'b0);
    xfer_a(8'($urandom), 8'($urandom), 1'b0, 0, 1'b0);
`ifdef SPI_LOOPBACK_EN
    a_if.loopback = 1'b1;
    xfer_a(8'h5A, 8'hC3, 1'b0, 0, 1'b0);
    a_if.loopback = 1'b0;
`endif
    err_c();
    xfer_b(128'h00112233445566778899AABBCCDDEEFF, {$urandom, $urandom, $urandom, $urandom});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
